// File: rtl/vio_bridge_pkg.sv
// Shared definitions for the VIO <-> lab-design bridge.
//   SEG_BYTE_W / SEG_BLANK : layout and blank value of one captured digit.
//   BTN_IDLE / BTN_PRESS   : per-button pulse state encoding.
//   onehot_t, onehot_decode: one-hot index extraction for the anode scan.
package vio_bridge_pkg;

    localparam int         SEG_BYTE_W = 8;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // Widest anode bus the decoder handles; narrower buses are zero-extended.
    localparam int MAX_DIGITS = 32;

    localparam logic [0:0] BTN_IDLE  = 1'b0;
    localparam logic [0:0] BTN_PRESS = 1'b1;

    typedef struct packed {
        logic       valid;  // exactly one bit set
        logic [4:0] idx;    // position of that bit (meaningful only when valid)
    } onehot_t;

    function automatic onehot_t onehot_decode(input logic [MAX_DIGITS-1:0] v);
        onehot_t r;
        int      ones;
        r.valid = 1'b0;
        r.idx   = '0;
        ones    = 0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (v[i]) begin
                ones  = ones + 1;
                r.idx = 5'(i);
            end
        end
        r.valid = (ones == 1);
        return r;
    endfunction

endpackage

// File: rtl/btn_pulser.sv
// One virtual push-button.
//   clk, rst : shared clock, synchronous active-high reset
//   req      : request level from VIO
//   mode     : 0 = pulse (rising edge -> PRESS_CYCLES-long pulse), 1 = level passthrough
//   btn      : registered drive to the lab design
module btn_pulser
    import vio_bridge_pkg::*;
#(
    parameter int PRESS_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic mode,
    output logic btn
);

    localparam int             CW       = $clog2(PRESS_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(PRESS_CYCLES - 1);

    logic          req_q;
    logic          armed;
    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          edge_det;

    // armed masks the first cycle after reset: req_q restarts at 0, so a
    // request held through reset would otherwise look like a fresh edge.
    assign edge_det = req & ~req_q & armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= 1'b0;
            armed <= 1'b0;
            state <= BTN_IDLE;
            cnt   <= '0;
            btn   <= 1'b0;
        end else begin
            req_q <= req;
            armed <= 1'b1;
            if (mode) begin
                // Level mode: btn ends up equal to req_q; any press is dropped.
                state <= BTN_IDLE;
                cnt   <= '0;
                btn   <= req;
            end else begin
                case (state)
                    BTN_IDLE: begin
                        if (edge_det) begin
                            state <= BTN_PRESS;
                            cnt   <= CNT_LOAD;
                            btn   <= 1'b1;
                        end else begin
                            btn   <= 1'b0;
                        end
                    end
                    BTN_PRESS: begin
                        // Edges here are ignored; cnt counts remaining high cycles.
                        if (cnt == '0) begin
                            state <= BTN_IDLE;
                            btn   <= 1'b0;
                        end else begin
                            cnt   <= cnt - 1'b1;
                            btn   <= 1'b1;
                        end
                    end
                    default: begin
                        state <= BTN_IDLE;
                        btn   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/vio_io_bridge.sv
// Bridge between the Vivado VIO core and a lab top design.
//   vio_btn_req/vio_btn_mode -> btn : per-button press pulses or level passthrough
//   vio_sw -> sw, dut_led -> led_q  : one-cycle registered copies
//   dut_anode/dut_cathode/dut_dp    : scanned display, captured per digit into
//                                     seg_capture (byte k = {dp,cathode} of digit k)
//                                     with digit_valid[k] set once digit k latched.
// NUM_DIGITS must not exceed vio_bridge_pkg::MAX_DIGITS.
module vio_io_bridge
    import vio_bridge_pkg::*;
#(
    parameter int NUM_BTNS         = 5,
    parameter int NUM_SW           = 16,
    parameter int NUM_LED          = 16,
    parameter int NUM_DIGITS       = 8,
    parameter int PRESS_CYCLES     = 1000000,
    parameter int STABLE_CYCLES    = 4,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_BTNS-1:0]              vio_btn_req,
    input  logic [NUM_BTNS-1:0]              vio_btn_mode,
    input  logic [NUM_SW-1:0]                vio_sw,
    output logic [NUM_BTNS-1:0]              btn,
    output logic [NUM_SW-1:0]                sw,
    input  logic [NUM_DIGITS-1:0]            dut_anode,
    input  logic [6:0]                       dut_cathode,
    input  logic                             dut_dp,
    input  logic [NUM_LED-1:0]               dut_led,
    output logic [NUM_LED-1:0]               led_q,
    output logic [SEG_BYTE_W*NUM_DIGITS-1:0] seg_capture,
    output logic [NUM_DIGITS-1:0]            digit_valid
);

    localparam int              STW        = $clog2(STABLE_CYCLES + 1);
    localparam logic [STW-1:0]  STABLE_MAX = STW'(STABLE_CYCLES);

    // ---------------- buttons ----------------
    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        btn_pulser #(
            .PRESS_CYCLES (PRESS_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst  (rst),
            .req  (vio_btn_req[g]),
            .mode (vio_btn_mode[g]),
            .btn  (btn[g])
        );
    end

    // ---------------- switches / LEDs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sw    <= '0;
            led_q <= '0;
        end else begin
            sw    <= vio_sw;
            led_q <= dut_led;
        end
    end

    // ---------------- display capture ----------------
    logic [NUM_DIGITS-1:0]   anode_hot;
    logic [MAX_DIGITS-1:0]   anode_ext;
    onehot_t                 sel;
    logic [SEG_BYTE_W-1:0]   sample;
    logic [SEG_BYTE_W-1:0]   prev_sample;
    logic [4:0]              prev_idx;
    logic                    prev_valid;
    logic [STW-1:0]          stab_cnt;
    logic [STW-1:0]          stab_next;
    logic                    write_en;

    assign anode_hot = (ANODE_ACTIVE_LOW != 0) ? ~dut_anode : dut_anode;
    assign anode_ext = MAX_DIGITS'(anode_hot);
    assign sel       = onehot_decode(anode_ext);
    assign sample    = {dut_dp, dut_cathode};

    // Run length of identical valid samples, saturating at STABLE_CYCLES.
    always_comb begin
        stab_next = '0;
        if (sel.valid) begin
            if (prev_valid && (sample == prev_sample) && (sel.idx == prev_idx)) begin
                stab_next = (stab_cnt == STABLE_MAX) ? STABLE_MAX : stab_cnt + 1'b1;
            end else begin
                stab_next = STW'(1);
            end
        end
    end

    // Rewrites the same byte every cycle while the run stays saturated.
    assign write_en = sel.valid && (stab_next == STABLE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample <= '0;
            prev_idx    <= '0;
            prev_valid  <= 1'b0;
            stab_cnt    <= '0;
            seg_capture <= {NUM_DIGITS{SEG_BLANK}};
            digit_valid <= '0;
        end else begin
            prev_sample <= sample;
            prev_idx    <= sel.idx;
            prev_valid  <= sel.valid;
            stab_cnt    <= stab_next;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (write_en && (sel.idx == 5'(k))) begin
                    seg_capture[k*SEG_BYTE_W +: SEG_BYTE_W] <= sample;
                    digit_valid[k]                          <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vio_io_bridge.sv
module tb_vio_io_bridge;

  localparam int NB   = 5;
  localparam int NSW  = 16;
  localparam int NLED = 16;
  localparam int ND   = 8;
  localparam int PC   = 4;
  localparam int ST   = 4;
  localparam int ALOW = 1;
  localparam int HMAX = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB-1:0]     vio_btn_req;
  logic [NB-1:0]     vio_btn_mode;
  logic [NSW-1:0]    vio_sw;
  logic [NB-1:0]     btn;
  logic [NSW-1:0]    sw;
  logic [ND-1:0]     dut_anode;
  logic [6:0]        dut_cathode;
  logic              dut_dp;
  logic [NLED-1:0]   dut_led;
  logic [NLED-1:0]   led_q;
  logic [8*ND-1:0]   seg_capture;
  logic [ND-1:0]     digit_valid;

  vio_io_bridge #(
    .NUM_BTNS         (NB),
    .NUM_SW           (NSW),
    .NUM_LED          (NLED),
    .NUM_DIGITS       (ND),
    .PRESS_CYCLES     (PC),
    .STABLE_CYCLES    (ST),
    .ANODE_ACTIVE_LOW (ALOW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vio_btn_req  (vio_btn_req),
    .vio_btn_mode (vio_btn_mode),
    .vio_sw       (vio_sw),
    .btn          (btn),
    .sw           (sw),
    .dut_anode    (dut_anode),
    .dut_cathode  (dut_cathode),
    .dut_dp       (dut_dp),
    .dut_led      (dut_led),
    .led_q        (led_q),
    .seg_capture  (seg_capture),
    .digit_valid  (digit_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A pulse started by an accepted edge in cycle n keeps btn high in cycles
  // n+1..n+PC; pulse_end records the last such cycle. A digit is latched once
  // the last ST samples (inclusive) are valid and identical.
  logic [NB-1:0]   exp_btn;
  logic [NSW-1:0]  exp_sw;
  logic [NLED-1:0] exp_led;
  logic [63:0]     exp_seg;
  logic [ND-1:0]   exp_dv;
  int              pulse_end [NB];
  logic [NB-1:0]   prev_req;
  int              cyc = 0;
  bit              h_ok [HMAX];
  int              h_k  [HMAX];
  logic [7:0]      h_s  [HMAX];

  always @(posedge clk) begin
    logic [ND-1:0] norm;
    int            run;
    int            kk;
    if (cyc < HMAX) begin
      if (rst) begin
        exp_btn  = '0;
        exp_sw   = '0;
        exp_led  = '0;
        exp_seg  = {8{8'hFF}};
        exp_dv   = '0;
        prev_req = '1;  // a request held across reset never counts as an edge
        for (int i = 0; i < NB; i++) pulse_end[i] = -1;
        h_ok[cyc] = 1'b0;
        h_k[cyc]  = -1;
        h_s[cyc]  = 8'h00;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (vio_btn_mode[i]) begin
            pulse_end[i] = -1;
            exp_btn[i]   = vio_btn_req[i];
          end else begin
            if (vio_btn_req[i] && !prev_req[i] && cyc > pulse_end[i])
              pulse_end[i] = cyc + PC;
            exp_btn[i] = (cyc + 1 <= pulse_end[i]);
          end
        end
        prev_req = vio_btn_req;
        exp_sw   = vio_sw;
        exp_led  = dut_led;
        norm = (ALOW != 0) ? ~dut_anode : dut_anode;
        kk = -1;
        for (int d = 0; d < ND; d++) if (norm[d]) kk = d;
        h_ok[cyc] = ($countones(norm) == 1);
        h_k[cyc]  = kk;
        h_s[cyc]  = {dut_dp, dut_cathode};
        run = 0;
        for (int j = cyc; j >= 0; j--) begin
          if (run >= ST) break;
          if (h_ok[j] && h_k[j] == kk && h_s[j] == h_s[cyc]) run++;
          else break;
        end
        if (h_ok[cyc] && run >= ST) begin
          exp_seg[kk*8 +: 8] = h_s[cyc];
          exp_dv[kk]         = 1'b1;
        end
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("btn",         64'(btn),         64'(exp_btn));
      check("sw",          64'(sw),          64'(exp_sw));
      check("led_q",       64'(led_q),       64'(exp_led));
      check("seg_capture", 64'(seg_capture), exp_seg);
      check("digit_valid", 64'(digit_valid), 64'(exp_dv));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_seg(input logic [7:0] an, input logic [7:0] s);
    dut_anode            = an;
    {dut_dp, dut_cathode} = s;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int hi_cnt;
    rst          = 1'b1;
    vio_btn_req  = '0;
    vio_btn_mode = '0;
    vio_sw       = '0;
    dut_led      = '0;
    set_seg(8'hFF, 8'h00);
    tick(1);
    check_en = 1'b1;
    tick(2);
    check("rst_btn", 64'(btn), 64'h0);
    check("rst_seg", 64'(seg_capture), 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_dv",  64'(digit_valid), 64'h0);
    rst = 1'b0;

    // Registered copies.
    vio_sw  = 16'hA5C3;
    dut_led = 16'h1234;
    tick(1);
    check("sw_copy",  64'(sw),    64'hA5C3);
    check("led_copy", 64'(led_q), 64'h1234);
    tick(2);

    // Pulse on button 2: high for exactly 4 cycles, then low while held.
    vio_btn_req = 5'b00100;
    for (int c = 0; c < PC; c++) begin
      tick(1);
      check("pulse_hi", 64'(btn), 64'h04);
    end
    tick(1);
    check("pulse_end", 64'(btn), 64'h00);
    tick(3);
    check("pulse_held", 64'(btn), 64'h00);
    vio_btn_req = '0;
    tick(2);

    // Re-trigger during press is ignored.
    vio_btn_req = 5'b00001; tick(1); check("retrig_c11", 64'(btn), 64'h01);
    vio_btn_req = 5'b00000; tick(1); check("retrig_c12", 64'(btn), 64'h01);
    vio_btn_req = 5'b00001; tick(1); check("retrig_c13", 64'(btn), 64'h01);
    tick(1); check("retrig_c14", 64'(btn), 64'h01);
    tick(1); check("retrig_c15", 64'(btn), 64'h00);
    vio_btn_req = 5'b00000;
    tick(4);
    vio_btn_req = 5'b00001;
    hi_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      hi_cnt += int'(btn[0]);
    end
    check("second_pulse_len", 64'(hi_cnt), 64'd4);
    vio_btn_req = '0;
    tick(2);

    // Level mode on button 1.
    vio_btn_mode = 5'b00010;
    vio_btn_req = 5'b00010; tick(1); check("level_1", 64'(btn), 64'h02);
    vio_btn_req = 5'b00000; tick(1); check("level_0", 64'(btn), 64'h00);
    vio_btn_req = 5'b00010; tick(1); check("level_1b", 64'(btn), 64'h02);
    vio_btn_req = 5'b00000; tick(1);

    // Abort a press by switching to level mode.
    vio_btn_mode = 5'b00000; tick(1); check("to_pulse", 64'(btn), 64'h00);
    vio_btn_req = 5'b00010; tick(1); check("abort_pre1", 64'(btn), 64'h02);
    tick(1); check("abort_pre2", 64'(btn), 64'h02);
    vio_btn_mode = 5'b00010; vio_btn_req = 5'b00000;
    tick(1); check("abort_now", 64'(btn), 64'h00);
    // Back to pulse with request already high: no pulse.
    vio_btn_req = 5'b00010; tick(1); check("level_held", 64'(btn), 64'h02);
    vio_btn_mode = 5'b00000; tick(1); check("no_pulse_held", 64'(btn), 64'h00);
    tick(5);
    vio_btn_req = '0;
    tick(2);

    // Invalid anode scans never write.
    for (int i = 0; i < 10; i++) begin
      set_seg((i < 5) ? 8'hFF : 8'hF3, 8'(8'h11 * i));
      tick(1);
    end
    check("inv_seg", 64'(seg_capture), 64'hFFFF_FFFF_FFFF_FFFF);
    check("inv_dv",  64'(digit_valid), 64'h0);

    // Only three stable samples: nothing written.
    set_seg(8'hFB, 8'hA4); tick(3);
    set_seg(8'hFF, 8'hA4); tick(1);
    check("short_dv", 64'(digit_valid), 64'h0);

    // Four stable samples on digit 2.
    set_seg(8'hFB, 8'hA4); tick(3);
    check("cap3_dv", 64'(digit_valid), 64'h0);
    tick(1);
    check("cap4_byte", 64'(seg_capture[23:16]), 64'hA4);
    check("cap4_dv",   64'(digit_valid), 64'h04);

    // Full scan, 16 cycles per digit.
    for (int d = 0; d < ND; d++) begin
      set_seg(~(8'(1) << d), 8'(8'hC0 + 8 * d));
      tick(16);
    end
    set_seg(8'hFF, 8'h00);
    tick(1);
    check("scan_dv", 64'(digit_valid), 64'hFF);
    check("scan_seg", 64'(seg_capture), 64'hF8F0_E8E0_D8D0_C8C0);

    // Reset mid-press and after captures.
    vio_btn_req = 5'b01000;
    tick(2);
    check("rst_mid_press", 64'(btn), 64'h08);
    rst = 1'b1;
    tick(1);
    check("rst2_btn", 64'(btn), 64'h0);
    check("rst2_seg", 64'(seg_capture), 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst2_dv",  64'(digit_valid), 64'h0);
    rst = 1'b0;
    tick(8);
    check("held_after_rst", 64'(btn), 64'h0);
    vio_btn_req = '0;
    tick(2);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
